// File: rtl/mctr_pkg.sv
// rtl/mctr_pkg.sv - shared encodings for the multi-cycle MIPS main control unit
package mctr_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXEC  = 4'd6,
    S_R_WB    = 4'd7,
    S_I_EXEC  = 4'd8,
    S_I_WB    = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JAL     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       irWrite;
    logic       aluSrcA;
    logic       regWrite;
    logic [1:0] regDst;
    logic [1:0] pcSource;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic       instrDone;
    logic       illegalOp;
  } ctrl_t;

  // S_FETCH doubles as the "unsupported opcode" answer
  function automatic state_t decodeTarget(input logic [5:0] op, input bit enImm,
                                          input bit enJal);
    case (op)
      OP_RTYPE:                         return S_R_EXEC;
      OP_LW, OP_SW:                     return S_MEM_ADR;
      OP_BEQ:                           return S_BRANCH;
      OP_J:                             return S_JUMP;
      OP_JAL:                           return enJal ? S_JAL : S_FETCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return enImm ? S_I_EXEC : S_FETCH;
      default:                          return S_FETCH;
    endcase
  endfunction

  function automatic logic [2:0] immAluOp(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mctr_decode.sv
// rtl/mctr_decode.sv - combinational control word for each controller state
module mctr_decode
  import mctr_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_IMM    = 1'b1,
  parameter bit ENABLE_JAL    = 1'b1
) (
  input  state_t      state,
  input  logic [5:0]  opCode,
  input  logic        memReady,
  output ctrl_t       ctrl
);

  logic memDone;
  assign memDone = MEM_HANDSHAKE ? memReady : 1'b1;

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.irWrite = memDone;
        ctrl.pcWrite = memDone;
      end
      S_DECODE: begin
        ctrl.aluSrcB   = SRCB_BRANCH;
        ctrl.illegalOp = (decodeTarget(opCode, ENABLE_IMM, ENABLE_JAL) == S_FETCH);
      end
      S_MEM_ADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.memToReg  = 1'b1;
        ctrl.regDst    = DST_RT;
        ctrl.instrDone = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.memWrite  = 1'b1;
        ctrl.iorD      = 1'b1;
        ctrl.instrDone = memDone;
      end
      S_R_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REG;
        ctrl.aluOp   = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.regDst    = DST_RD;
        ctrl.instrDone = 1'b1;
      end
      S_I_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = immAluOp(opCode);
      end
      S_I_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.regDst    = DST_RT;
        ctrl.instrDone = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_REG;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
        ctrl.instrDone   = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcWrite   = 1'b1;
        ctrl.pcSource  = PCSRC_JUMP;
        ctrl.instrDone = 1'b1;
      end
      S_JAL: begin
        ctrl.pcWrite   = 1'b1;
        ctrl.pcSource  = PCSRC_JUMP;
        ctrl.regWrite  = 1'b1;
        ctrl.regDst    = DST_RA;
        ctrl.instrDone = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctr.sv
// rtl/multicycle_ctr.sv - multi-cycle MIPS main control FSM (state/opcode registers, next state)
module multicycle_ctr
  import mctr_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_IMM    = 1'b1,
  parameter bit ENABLE_JAL    = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opCode,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               memToReg,
  output logic               irWrite,
  output logic               aluSrcA,
  output logic               regWrite,
  output logic [1:0]         regDst,
  output logic [1:0]         pcSource,
  output logic [1:0]         aluSrcB,
  output logic [2:0]         aluOp,
  output logic               instrDone,
  output logic               illegalOp,
  output logic [STATE_W-1:0] state
);

  state_t     stateReg, stateNext;
  logic [5:0] opReg, activeOp;
  logic       memDone;
  ctrl_t      ctrl;

  assign memDone  = MEM_HANDSHAKE ? memReady : 1'b1;
  // DECODE must react to the live opcode; later states use the latched copy
  assign activeOp = (stateReg == S_DECODE) ? opCode : opReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= S_FETCH;
      opReg    <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == S_DECODE) opReg <= opCode;
    end
  end

  always_comb begin
    stateNext = S_FETCH;
    case (stateReg)
      S_FETCH:   stateNext = memDone ? S_DECODE : S_FETCH;
      S_DECODE:  stateNext = decodeTarget(opCode, ENABLE_IMM, ENABLE_JAL);
      S_MEM_ADR: stateNext = (opReg == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  stateNext = memDone ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  stateNext = memDone ? S_FETCH : S_MEM_WR;
      S_R_EXEC:  stateNext = S_R_WB;
      S_I_EXEC:  stateNext = S_I_WB;
      default:   stateNext = S_FETCH;
    endcase
  end

  mctr_decode #(
    .MEM_HANDSHAKE(MEM_HANDSHAKE),
    .ENABLE_IMM   (ENABLE_IMM),
    .ENABLE_JAL   (ENABLE_JAL)
  ) uDecode (
    .state   (stateReg),
    .opCode  (activeOp),
    .memReady(memReady),
    .ctrl    (ctrl)
  );

  // Strobes and pulses are held off for as long as reset is low
  assign pcWrite     = ctrl.pcWrite     & reset;
  assign pcWriteCond = ctrl.pcWriteCond & reset;
  assign memRead     = ctrl.memRead     & reset;
  assign memWrite    = ctrl.memWrite    & reset;
  assign irWrite     = ctrl.irWrite     & reset;
  assign regWrite    = ctrl.regWrite    & reset;
  assign instrDone   = ctrl.instrDone   & reset;
  assign illegalOp   = ctrl.illegalOp   & reset;
  assign iorD        = ctrl.iorD;
  assign memToReg    = ctrl.memToReg;
  assign aluSrcA     = ctrl.aluSrcA;
  assign regDst      = ctrl.regDst;
  assign pcSource    = ctrl.pcSource;
  assign aluSrcB     = ctrl.aluSrcB;
  assign aluOp       = ctrl.aluOp;
  assign state       = STATE_W'(stateReg);

endmodule

// File: tb/tb_multicycle_ctr.sv
// tb/tb_multicycle_ctr.sv - scoreboard bench for multicycle_ctr with random instruction streams
module tb_multicycle_ctr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, memReady;
  logic [5:0] opCode;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite, aluSrcA, regWrite;
  logic [1:0] regDst, pcSource, aluSrcB;
  logic [2:0] aluOp;
  logic       instrDone, illegalOp;
  logic [3:0] state;

  logic       reset2;
  logic [5:0] opCode2;
  logic       pcWrite2, pcWriteCond2, iorD2, memRead2, memWrite2, memToReg2, irWrite2, aluSrcA2, regWrite2;
  logic [1:0] regDst2, pcSource2, aluSrcB2;
  logic [2:0] aluOp2;
  logic       instrDone2, illegalOp2;
  logic [3:0] state2;

  multicycle_ctr #(.MEM_HANDSHAKE(1'b1), .ENABLE_IMM(1'b1), .ENABLE_JAL(1'b1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .memToReg(memToReg), .irWrite(irWrite), .aluSrcA(aluSrcA),
    .regWrite(regWrite), .regDst(regDst), .pcSource(pcSource), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .instrDone(instrDone), .illegalOp(illegalOp), .state(state));

  multicycle_ctr #(.MEM_HANDSHAKE(1'b0), .ENABLE_IMM(1'b0), .ENABLE_JAL(1'b0), .STATE_W(4)) dut2 (
    .clk(clk), .reset(reset2), .opCode(opCode2), .memReady(1'b0),
    .pcWrite(pcWrite2), .pcWriteCond(pcWriteCond2), .iorD(iorD2), .memRead(memRead2),
    .memWrite(memWrite2), .memToReg(memToReg2), .irWrite(irWrite2), .aluSrcA(aluSrcA2),
    .regWrite(regWrite2), .regDst(regDst2), .pcSource(pcSource2), .aluSrcB(aluSrcB2),
    .aluOp(aluOp2), .instrDone(instrDone2), .illegalOp(illegalOp2), .state(state2));

  int nCmp = 0;
  int nErr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         lat;
    bit         ill;
    logic [8:0] term;
    int         rdCnt;
    int         wrCnt;
    int         rwCnt;
    int         aluIdx;
    logic [2:0] aluExp;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  bit   sbActive = 1'b0;

  int         cyc = 0, rdCnt = 0, wrCnt = 0, irCnt = 0, rwCnt = 0;
  logic [2:0] aluSeen = '0;

  // Monitor: tallies per-instruction activity and scores it when the DUT ends an instruction
  always @(negedge clk) begin
    if (sbActive) begin
      if (memRead)  rdCnt++;
      if (memWrite) wrCnt++;
      if (irWrite)  irCnt++;
      if (regWrite) rwCnt++;
      if (sbq.size() > 0 && cyc == sbq[0].aluIdx) aluSeen = aluOp;
      if (instrDone || illegalOp) begin
        if (sbq.size() == 0) chk("unexpected_completion", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("latency", cyc + 1, e.lat);
          chk("illegal_flag", int'(illegalOp), int'(e.ill));
          chk("done_flag", int'(instrDone), int'(!e.ill));
          chk("terminal_word",
              int'({pcWrite, pcWriteCond, memWrite, regWrite, memToReg, regDst, pcSource}),
              int'(e.term));
          chk("memread_cycles", rdCnt, e.rdCnt);
          chk("memwrite_cycles", wrCnt, e.wrCnt);
          chk("irwrite_cycles", irCnt, 1);
          chk("regwrite_cycles", rwCnt, e.rwCnt);
          if (e.aluIdx >= 0) chk("exec_aluop", int'(aluSeen), int'(e.aluExp));
        end
        cyc = 0; rdCnt = 0; wrCnt = 0; irCnt = 0; rwCnt = 0;
      end else begin
        cyc++;
        if (cyc > 64) begin
          chk("completion_timeout", cyc, 0);
          cyc = 0; rdCnt = 0; wrCnt = 0; irCnt = 0; rwCnt = 0;
        end
      end
    end
  end

  logic [5:0] opTab [0:9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
                              6'b000011, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

  function automatic bit isLegal(input logic [5:0] op);
    foreach (opTab[i]) if (opTab[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         kind, fS, mS;
    logic [5:0] op;
    bit         mr[$];
    logic [5:0] oc[$];
    exp_t       x;

    reset = 1'b0; reset2 = 1'b0; memReady = 1'b0; opCode = '0; opCode2 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_memRead", int'(memRead), 0);
    chk("rst_pcWrite", int'(pcWrite), 0);
    chk("rst_irWrite", int'(irWrite), 0);
    chk("rst_iorD", int'(iorD), 0);
    chk("rst_aluSrcB", int'(aluSrcB), 1);

    @(posedge clk); #1;
    reset = 1'b1; memReady = 1'b1; opCode = 6'b100011;
    @(negedge clk);
    chk("post_rst_memRead", int'(memRead), 1);
    chk("post_rst_iorD", int'(iorD), 0);
    chk("post_rst_irWrite", int'(irWrite), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    memReady = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("memrd_state", int'(state), 3);
    chk("memrd_iorD", int'(iorD), 1);
    #1 reset = 1'b0;
    #1;
    chk("midrd_rst_state", int'(state), 0);
    chk("midrd_rst_memRead", int'(memRead), 0);
    chk("midrd_rst_iorD", int'(iorD), 0);
    chk("midrd_rst_aluSrcB", int'(aluSrcB), 1);
    @(posedge clk); #1;
    reset = 1'b1; memReady = 1'b1;
    @(negedge clk);
    chk("midrd_rel_memRead", int'(memRead), 1);
    chk("midrd_rel_iorD", int'(iorD), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Random instruction stream: stalls in memory states, garbage opcode outside DECODE
    sbActive = 1'b1;
    for (int n = 0; n < 160; n++) begin
      kind = $urandom_range(0, 10);
      if (kind < 10) op = opTab[kind];
      else begin
        op = 6'($urandom);
        while (isLegal(op)) op = 6'($urandom);
      end
      fS = $urandom_range(0, 2);
      mS = (kind <= 1) ? $urandom_range(0, 3) : 0;
      mr.delete(); oc.delete();
      repeat (fS) begin mr.push_back(1'b0); oc.push_back(6'($urandom)); end
      mr.push_back(1'b1); oc.push_back(6'($urandom));
      mr.push_back(1'($urandom)); oc.push_back(op);

      x.ill = 1'b0; x.term = '0; x.rdCnt = fS + 1; x.wrCnt = 0; x.rwCnt = 0;
      x.aluIdx = fS + 2; x.aluExp = 3'b000;
      case (kind)
        0: begin
          x.lat = fS + mS + 5; x.term = 9'b0_0_0_1_1_00_00; x.rdCnt = fS + mS + 2; x.rwCnt = 1;
          mr.push_back(1'($urandom)); oc.push_back(6'($urandom));
          repeat (mS) begin mr.push_back(1'b0); oc.push_back(6'($urandom)); end
          mr.push_back(1'b1); oc.push_back(6'($urandom));
          mr.push_back(1'($urandom)); oc.push_back(6'($urandom));
        end
        1: begin
          x.lat = fS + mS + 4; x.term = 9'b0_0_1_0_0_00_00; x.wrCnt = mS + 1;
          mr.push_back(1'($urandom)); oc.push_back(6'($urandom));
          repeat (mS) begin mr.push_back(1'b0); oc.push_back(6'($urandom)); end
          mr.push_back(1'b1); oc.push_back(6'($urandom));
        end
        2, 6, 7, 8, 9: begin
          x.lat = fS + 4; x.rwCnt = 1;
          x.term = (kind == 2) ? 9'b0_0_0_1_0_01_00 : 9'b0_0_0_1_0_00_00;
          case (kind)
            2: x.aluExp = 3'b010;
            7: x.aluExp = 3'b011;
            8: x.aluExp = 3'b100;
            9: x.aluExp = 3'b101;
            default: x.aluExp = 3'b000;
          endcase
          repeat (2) begin mr.push_back(1'($urandom)); oc.push_back(6'($urandom)); end
        end
        3, 4, 5: begin
          x.lat = fS + 3;
          if (kind == 3) begin x.term = 9'b0_1_0_0_0_00_01; x.aluExp = 3'b001; end
          else if (kind == 4) x.term = 9'b1_0_0_0_0_00_10;
          else begin x.term = 9'b1_0_0_1_0_10_10; x.rwCnt = 1; end
          mr.push_back(1'($urandom)); oc.push_back(6'($urandom));
        end
        default: begin
          x.lat = fS + 2; x.ill = 1'b1; x.aluIdx = -1;
        end
      endcase
      sbq.push_back(x);
      foreach (mr[k]) begin
        memReady = mr[k]; opCode = oc[k];
        @(posedge clk); #1;
      end
    end
    sbActive = 1'b0;
    chk("scoreboard_drained", sbq.size(), 0);

    // No handshake, memReady tied low, I-type and jal disabled
    opCode2 = 6'b100011;
    @(posedge clk); #1;
    reset2 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("nohs_lw_done", int'(instrDone2), int'(c == 5));
      if (c == 5) begin
        chk("nohs_lw_regWrite", int'(regWrite2), 1);
        chk("nohs_lw_memToReg", int'(memToReg2), 1);
      end
    end
    opCode2 = 6'b001101;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("noimm_ori_illegal", int'(illegalOp2), int'(c == 2));
      chk("noimm_ori_done", int'(instrDone2), 0);
      if (c == 3) chk("noimm_ori_back_to_fetch", int'(state2), 0);
    end
    opCode2 = 6'b000011;
    @(negedge clk);
    chk("nojal_illegal", int'(illegalOp2), 1);
    chk("nojal_state", int'(state2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/multicycle_ctr.md
# multicycle_ctr

Parametrised multi-cycle main control unit for the lab MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine. The FSM steps each instruction through fetch, decode, execute, memory and write-back cycles, and stalls on a memory-ready handshake. It sits between the instruction register's opcode field and the shared ALU/memory/register-file datapath, and drives one control word per cycle.

## Interface
- MEM_HANDSHAKE, 1: 1 = memory states wait for memReady; 0 = memReady ignored, memory is single-cycle.
- ENABLE_IMM, 1: 1 = decode addi/andi/ori/slti (I-type ALU); 0 = those opcodes are illegal.
- ENABLE_JAL, 1: 1 = decode jal; 0 = jal is illegal.
- STATE_W, 4: width of the debug state output.

- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opCode  input  6  instruction[31:26] from the IR, sampled in DECODE.
- memReady  input  1  memory access completes this cycle.
- pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite, aluSrcA, regWrite  output  1 each  datapath strobes/selects.
- regDst, pcSource, aluSrcB  output  2 each  regDst: 00 rt, 01 rd, 10 $31. pcSource: 00 ALU, 01 ALUOut, 10 jump target.
- aluOp  output  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt.
- instrDone  output  1  one-cycle pulse on an instruction's last cycle.
- illegalOp  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  output  STATE_W  current state, for debug.

## Operation
- States:
  - FETCH, DECODE
  - MEM_ADR, MEM_RD, MEM_WB, MEM_WR
  - R_EXEC, R_WB
  - I_EXEC, I_WB
  - BRANCH, JUMP, JAL
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=add, pcSource=00.
  - irWrite and pcWrite equal memReady (forced 1 when MEM_HANDSHAKE=0).
  - Advances to DECODE when they are 1; otherwise holds.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=add (branch target). Next state by opCode:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - 001000/001100/001101/001010 → I_EXEC
  - anything else → FETCH, with an illegalOp pulse
- MEM_ADR: aluSrcA=1, aluSrcB=10, aluOp=add. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: memRead=1, iorD=1. Holds until memReady, then goes to MEM_WB.
- MEM_WB: regWrite=1, memToReg=1, regDst=00.
- MEM_WR: memWrite=1, iorD=1. Holds until memReady.
- R_EXEC: aluSrcA=1, aluSrcB=00, aluOp=funct.
- R_WB: regWrite=1, regDst=01.
- I_EXEC: aluSrcA=1, aluSrcB=10. aluOp is add/and/or/slt for opcodes 001000/001100/001101/001010.
- I_WB: regWrite=1, regDst=00.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=sub, pcWriteCond=1, pcSource=01.
- JUMP: pcWrite=1, pcSource=10.
- JAL: pcWrite=1, pcSource=10, regWrite=1, regDst=10, memToReg=0. The PC written to $31 comes from the datapath.
- Terminal states return to FETCH and assert instrDone: MEM_WB, MEM_WR (when it completes), R_WB, I_WB, BRANCH, JUMP, JAL.
- Every output not listed for a state is 0.
- The opcode is latched internally in DECODE. Changes to opCode in later states are ignored.

## Timing
- Reset low (any time, including mid-instruction):
  - state = FETCH immediately.
  - All strobes (pcWrite, pcWriteCond, memRead, memWrite, irWrite, regWrite) and the instrDone and illegalOp pulses are forced 0.
  - Selects take their FETCH values.
- First active edge after reset release performs the FETCH actions.
- Latency with memReady held at 1, counted in cycles from FETCH to instrDone inclusive:
  - lw: 5
  - sw, R-type, I-type: 4
  - beq, j, jal: 3
- Every cycle memReady is low in FETCH, MEM_RD or MEM_WR adds one cycle. The control word is held stable during the stall.
- memReady is don't-care in every other state.
- Transitions are Moore: outputs depend on the registered state only.
  - Exceptions: irWrite/pcWrite in FETCH and the exits from MEM_RD/MEM_WR, which also depend on memReady.
- illegalOp asserts in the DECODE cycle. The next cycle is FETCH; there is no instrDone for an illegal opcode.

## Structure
- Package mctr_pkg holds:
  - the state encoding (4-bit, FETCH=0)
  - opcode constants
  - aluOp codes
  - the pcSource, aluSrcB and regDst select encodings
- Sub-module mctr_decode: purely combinational map from state, latched opcode and memReady to the control word. The top holds only the state and opcode registers plus the next-state logic.

## Test plan
- Reset low mid-MEM_RD, then high → state=0 and all strobes 0 while low; next cycle memRead=1, iorD=0.
- opCode=100011, memReady=1 → FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB; instrDone high only in cycle 5, with regWrite=1 and memToReg=1.
- opCode=101011, memReady low for 3 cycles in MEM_WR → memWrite held 1 for 4 cycles; instrDone in cycle 7.
- opCode=000000, 000100, 000010, 000011 back-to-back → instrDone spacing 4, 3, 3, 3; JAL drives regDst=10, pcSource=10.
- opCode=001101 with ENABLE_IMM=1 → I_EXEC aluOp=100. With ENABLE_IMM=0 → illegalOp pulse in DECODE, then FETCH.
- MEM_HANDSHAKE=0 with memReady tied to 0 → lw still completes in 5 cycles.
